des_key_schedule: RTL and testbench
===================================

DES_KEY_SCHEDULE -- requirements
Module: des_key_schedule

Interface
REQ-001 Parameters: none; all widths are fixed by FIPS 46-3.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 start  input  1  request a new schedule; sampled only in IDLE.
REQ-005 decrypt  input  1  direction, sampled with start: 0 = K1..K16 (encrypt order), 1 = K16..K1 (decrypt order).
REQ-006 key_in  input  [64:1]  DES key, bit 1 = MSB; parity bits 8,16,...,64 ignored.
REQ-007 busy  output  1  high from the cycle after an accepted start until the final subkey handshake.
REQ-008 subkey_valid  output  1  subkey and round_idx are valid.
REQ-009 subkey_ready  input  1  consumer accepts the subkey when high with subkey_valid.
REQ-010 subkey  output  [48:1]  PC-2 output for the current round.
REQ-011 round_idx  output  [4:1]  DES round number minus 1 of the presented subkey (K1 = 0, K16 = 15).
REQ-012 done  output  1  one-cycle pulse the cycle after the 16th subkey is accepted.

Function
REQ-013 States: IDLE, RUN; reset enters IDLE.
REQ-014 IDLE with start=1: latch PC-1(key_in) into 28-bit C/D registers, latch decrypt, clear step counter, go to RUN.
REQ-015 Encrypt: the first subkey presented is PC-2(C1,D1), i.e. the load applies the round-1 left rotate of 1.
REQ-016 Decrypt: the first subkey presented is PC-2(C0,D0) = K16, with no rotate at load.
REQ-017 Encrypt left-rotate amounts per round 1..16: 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1; C and D rotate independently.
REQ-018 Decrypt right-rotate amounts applied after each accepted step 1..15: 1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
REQ-019 RUN: subkey_valid=1 in every cycle; subkey and round_idx are combinational from the C/D registers and the step counter, and stay stable while subkey_ready=0.
REQ-020 Handshake subkey_valid & subkey_ready: advance the step counter and rotate C/D for the next round; throughput is one subkey per cycle with subkey_ready held high.
REQ-021 round_idx equals step in encrypt mode and 15-step in decrypt mode.
REQ-022 Handshake on step 15: go to IDLE, pulse done in the next cycle, deassert busy and subkey_valid in that same cycle.
REQ-023 Latency: with subkey_ready=1 the first subkey_valid appears 1 cycle after start and done appears 17 cycles after start.
REQ-024 start in RUN is ignored, and key_in/decrypt changes in RUN have no effect.
REQ-025 start in the same cycle as the done pulse (already IDLE) is accepted normally.
REQ-026 After 16 rotates C/D equal their loaded value in both modes; this is a checkable invariant.
REQ-027 PC-1 and PC-2 follow FIPS 46-3 tables exactly, MSB-first numbering as bit 1.

Reset
REQ-028 rst_n=0 asynchronously forces IDLE, busy=0, subkey_valid=0, done=0, subkey=0, round_idx=0, and C/D/step=0.
REQ-029 Reset mid-RUN aborts the schedule with no done pulse; after release the block waits for a new start.
REQ-030 Release of rst_n takes effect at the next clock edge; start sampled in that edge is accepted.

Verification
REQ-031 Encrypt, key 133457799BBCDFF1, subkey_ready=1 -> 16 consecutive valid cycles; round_idx 0 = 1B02EFFC7072, round_idx 15 = CB3D8B0E17F5; done at cycle 17.
REQ-032 Decrypt, same key -> first subkey CB3D8B0E17F5 with round_idx 15, last 1B02EFFC7072 with round_idx 0; the sequence is the exact reverse of REQ-031.
REQ-033 Backpressure: subkey_ready low for 3 cycles at round_idx 4 -> subkey and round_idx are held and there is no skip or duplicate; done is delayed by 3 cycles.
REQ-034 Parity: key 133457799BBCDFF1 with all parity bits inverted -> subkeys identical to REQ-031.
REQ-035 Start pulsed in RUN with a different key -> the sequence is unaffected; start one cycle after done -> a new schedule begins.
REQ-036 rst_n low at round_idx 7 -> all outputs are 0 immediately and there is no done; a restart yields the full REQ-031 sequence.

Source files
------------

// File: rtl/des_key_schedule.sv
// des_key_schedule: DES (FIPS 46-3) subkey generator, K1..K16 or K16..K1, one subkey per valid/ready handshake
//   clk, rst_n          : clock, asynchronous active-low reset
//   start, decrypt      : request a schedule in IDLE; decrypt selects K16..K1 order
//   key_in [64:1]       : DES key, bit 1 is the MSB (key_in[64]); parity bits ignored
//   busy                : schedule in progress
//   subkey_valid/ready  : subkey handshake; subkey and round_idx held while not ready
//   subkey [48:1]       : PC-2 output of the presented round
//   round_idx [4:1]     : presented DES round minus 1
//   done                : one-cycle pulse after the 16th subkey is accepted
module des_key_schedule (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        decrypt,
  input  logic [64:1] key_in,
  output logic        busy,
  output logic        subkey_valid,
  input  logic        subkey_ready,
  output logic [48:1] subkey,
  output logic [4:1]  round_idx,
  output logic        done
);
  typedef enum logic {IDLE, RUN} state_e;
  localparam int PC1 [56] = '{57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
                              10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
                              63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
                              14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
  localparam int PC2 [48] = '{14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
                              23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
                              41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
                              44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
  // bit i set when the 0-based round i of the encrypt schedule shifts by 2
  localparam logic [15:0] TWO = 16'h7EFC;
  state_e      state_q;
  logic [27:0] c_q, d_q, c_d, d_d;
  logic [3:0]  step_q;
  logic        dec_q, done_q, run, two;
  logic [55:0] pc1, cd;
  logic [48:1] pc2;
  logic        unused_parity;
  function automatic logic [27:0] rot(input logic [27:0] x, input logic right, input logic by2);
    return right ? (by2 ? {x[1:0], x[27:2]} : {x[0], x[27:1]})
                 : (by2 ? {x[25:0], x[27:26]} : {x[26:0], x[27]});
  endfunction
  // DES bit n of the key is key_in[65-n]; DES bit n of C||D sits at index 56-n
  for (genvar i = 0; i < 56; i++) begin : g_pc1
    assign pc1[55-i] = key_in[65-PC1[i]];
  end
  assign cd = {c_q, d_q};
  for (genvar i = 0; i < 48; i++) begin : g_pc2
    assign pc2[48-i] = cd[56-PC2[i]];
  end
  assign unused_parity = ^{key_in[57], key_in[49], key_in[41], key_in[33],
                           key_in[25], key_in[17], key_in[9], key_in[1]};
  // decrypt undoes round 16-step; encrypt prepares round step+2 (wraps to the round-1 shift after the last step,
  // so C/D return to their loaded value after 16 rotates in both directions)
  assign two = TWO[dec_q ? ~step_q : step_q + 4'd1];
  assign c_d = rot(c_q, dec_q, two);
  assign d_d = rot(d_q, dec_q, two);
  assign run          = state_q == RUN;
  assign busy         = run;
  assign subkey_valid = run;
  assign done         = done_q;
  assign subkey       = run ? pc2 : '0;
  assign round_idx    = run ? (dec_q ? ~step_q : step_q) : '0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      c_q     <= '0;
      d_q     <= '0;
      step_q  <= '0;
      dec_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state_q == IDLE) begin
        if (start) begin
          state_q <= RUN;
          dec_q   <= decrypt;
          step_q  <= '0;
          c_q     <= decrypt ? pc1[55:28] : rot(pc1[55:28], 1'b0, 1'b0);
          d_q     <= decrypt ? pc1[27:0] : rot(pc1[27:0], 1'b0, 1'b0);
        end
      end else if (subkey_ready) begin
        c_q    <= c_d;
        d_q    <= d_d;
        step_q <= step_q + 4'd1;
        if (step_q == 4'd15) begin
          state_q <= IDLE;
          done_q  <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_des_key_schedule.sv
// tb_des_key_schedule: randomized self-checking bench against a table-driven DES key schedule model
module tb_des_key_schedule;
  localparam logic [63:0] KEY = 64'h133457799BBCDFF1;
  localparam logic [47:0] K1  = 48'h1B02EFFC7072;
  localparam logic [47:0] K16 = 48'hCB3D8B0E17F5;
  localparam int PC1 [56] = '{57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
                              10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
                              63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
                              14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
  localparam int PC2 [48] = '{14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
                              23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
                              41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
                              44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
  localparam int SH [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        decrypt = 1'b0;
  logic [63:0] key_in = '0;
  logic        busy, subkey_valid, done;
  logic        subkey_ready = 1'b1;
  logic [47:0] subkey;
  logic [3:0]  round_idx;
  logic [47:0] exp_k [16];
  logic [47:0] first_sk, last_sk;
  logic [3:0]  first_ri, last_ri;
  int checks = 0;
  int errors = 0;
  des_key_schedule dut (
    .clk(clk), .rst_n(rst_n), .start(start), .decrypt(decrypt), .key_in(key_in),
    .busy(busy), .subkey_valid(subkey_valid), .subkey_ready(subkey_ready),
    .subkey(subkey), .round_idx(round_idx), .done(done)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic logic [27:0] rotl28(input logic [27:0] x, input int s);
    logic [55:0] t;
    t = {x, x};
    return t[55-s -: 28];
  endfunction
  task automatic gen_keys(input logic [63:0] key);
    logic [27:0] c, d;
    logic [55:0] cd;
    int sh;
    for (int i = 0; i < 28; i++) begin
      c[27-i] = key[64-PC1[i]];
      d[27-i] = key[64-PC1[28+i]];
    end
    sh = 0;
    for (int r = 0; r < 16; r++) begin
      sh += SH[r];
      cd = {rotl28(c, sh % 28), rotl28(d, sh % 28)};
      for (int j = 0; j < 48; j++) exp_k[r][47-j] = cd[56-PC2[j]];
    end
  endtask
  task automatic run_sched(input logic [63:0] key, input logic dec, input int stall_at,
                           input int stall_len, input bit noise);
    int got, cyc, stalled, r;
    gen_keys(key);
    start = 1'b1;
    decrypt = dec;
    key_in = key;
    subkey_ready = 1'b1;
    @(negedge clk);
    cyc = 1;
    got = 0;
    stalled = 0;
    while (got < 16 && cyc < 64) begin
      r = dec ? 15 - got : got;
      check("valid", subkey_valid, 1);
      check("busy", busy, 1);
      check("done_early", done, 0);
      check("round_idx", round_idx, r);
      check("subkey", subkey, exp_k[r]);
      if (got == 0) begin
        first_sk = subkey;
        first_ri = round_idx;
      end
      if (got == 15) begin
        last_sk = subkey;
        last_ri = round_idx;
      end
      subkey_ready = !(r == stall_at && stalled < stall_len);
      if (subkey_ready) got++;
      else stalled++;
      start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      if (noise) begin
        key_in = {$urandom, $urandom};
        decrypt = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    subkey_ready = 1'b1;
    check("subkeys_seen", got, 16);
    check("done", done, 1);
    check("done_latency", cyc, 17 + stall_len);
    check("busy_after", busy, 0);
    check("valid_after", subkey_valid, 0);
  endtask
  initial begin
    int guard;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_valid", subkey_valid, 0);
    check("rst_done", done, 0);
    check("rst_subkey", subkey, 0);
    check("rst_round", round_idx, 0);
    rst_n = 1'b1;
    run_sched(KEY, 1'b0, -1, 0, 1'b0);
    check("enc_first", first_sk, K1);
    check("enc_first_ri", first_ri, 0);
    check("enc_last", last_sk, K16);
    check("enc_last_ri", last_ri, 15);
    run_sched(KEY, 1'b1, -1, 0, 1'b0);
    check("dec_first", first_sk, K16);
    check("dec_first_ri", first_ri, 15);
    check("dec_last", last_sk, K1);
    check("dec_last_ri", last_ri, 0);
    @(negedge clk);
    check("done_pulse", done, 0);
    run_sched(KEY, 1'b0, 4, 3, 1'b1);
    @(negedge clk);
    run_sched(KEY ^ 64'h0101010101010101, 1'b0, -1, 0, 1'b0);
    check("par_first", first_sk, K1);
    check("par_last", last_sk, K16);
    start = 1'b1;
    key_in = KEY;
    decrypt = 1'b0;
    @(negedge clk);
    start = 1'b0;
    guard = 0;
    while (round_idx != 4'd7 && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    check("rst_reach7", round_idx, 7);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_valid", subkey_valid, 0);
    check("arst_subkey", subkey, 0);
    check("arst_round", round_idx, 0);
    check("arst_done", done, 0);
    repeat (3) begin
      @(negedge clk);
      check("arst_no_done", done, 0);
    end
    rst_n = 1'b1;
    run_sched(KEY, 1'b0, -1, 0, 1'b0);
    check("restart_first", first_sk, K1);
    check("restart_last", last_sk, K16);
    repeat (6) begin
      if ($urandom_range(0, 1) == 1) @(negedge clk);
      run_sched({$urandom, $urandom}, 1'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
                int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
